// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1) from the sysid slave, compares them against
// build-time values and reports pass / mismatch / timeout.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1511670715,
  parameter int unsigned CHECK_TIMESTAMP    = 1,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_timestamp
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        launch;

  logic        in_xfer;
  logic        completing;
  logic        expire;
  logic        ts_mismatch;

  // Transfer-phase decode and the final comparison (timestamp taken live from the bus)
  always_comb begin
    in_xfer     = (state == ID_REQ) || (state == ID_WAIT) ||
                  (state == TS_REQ) || (state == TS_WAIT);
    completing  = avm_readdatavalid && ((state == ID_WAIT) || (state == TS_WAIT));
    expire      = in_xfer && (tmo_cnt == LIMIT) && !completing;
    ts_mismatch = (captured_id != EXPECTED_ID) ||
                  ((CHECK_TIMESTAMP != 0) && (avm_readdata != EXPECTED_TIMESTAMP));
  end

  // Check sequencer with registered bus command and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      tmo_cnt            <= '0;
      launch             <= (AUTO_START != 0);
      avm_address        <= 1'b0;
      avm_read           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      id_ok              <= 1'b0;
      mismatch           <= 1'b0;
      timeout            <= 1'b0;
      captured_id        <= '0;
      captured_timestamp <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch || start) begin
            launch      <= 1'b0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            tmo_cnt     <= '0;
            state       <= ID_REQ;
          end
        end
        ID_REQ, TS_REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= (state == ID_REQ) ? ID_WAIT : TS_WAIT;
          end
        end
        ID_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (avm_readdatavalid) begin
            captured_id <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            tmo_cnt     <= '0;
            state       <= TS_REQ;
          end
        end
        TS_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (avm_readdatavalid) begin
            captured_timestamp <= avm_readdata;
            busy               <= 1'b0;
            done               <= 1'b1;
            mismatch           <= ts_mismatch;
            id_ok              <= !ts_mismatch;
            state              <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            done        <= 1'b0;
            id_ok       <= 1'b0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            tmo_cnt     <= '0;
            state       <= ID_REQ;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides whatever the per-state logic scheduled above; a
      // response arriving on the last allowed cycle is excluded by `expire`.
      if (expire) begin
        avm_read <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        timeout  <= 1'b1;
        id_ok    <= 1'b0;
        mismatch <= 1'b0;
        state    <= DONE;
      end
    end
  end

endmodule
